// File: rtl/uart_rx_if.sv
// uart_rx_if: serial input, frame configuration and received-word outputs of the UART receiver
interface uart_rx_if #(parameter int DATA_WIDTH = 8);
  logic                  RX_IN;
  logic [5:0]            PRESCALE;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  Par_Err;
  logic                  Stp_Err;
  logic                  Busy;
  modport master (output RX_IN, PRESCALE, PAR_EN, PAR_TYP,
                  input  P_DATA, Data_Valid, Par_Err, Stp_Err, Busy);
  modport slave  (input  RX_IN, PRESCALE, PAR_EN, PAR_TYP,
                  output P_DATA, Data_Valid, Par_Err, Stp_Err, Busy);
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver with 3-sample majority vote, parity and stop checking
module uart_rx_core #(
  parameter int DATA_WIDTH = 8
) (
  input logic       CLK,
  input logic       RST,
  uart_rx_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                r_state, w_next;
  logic                  r_prev, r_pe, r_pt, r_perr, r_serr;
  logic                  r_dv, r_par_err, r_stp_err;
  logic [5:0]            r_p, r_edge;
  logic [4:0]            r_bit;
  logic [2:0]            r_smp;
  logic [DATA_WIDTH-1:0] r_shift, r_data;
  logic                  w_start, w_last, w_res, w_maj, w_good;
  logic [5:0]            w_half, w_psel;
  assign w_psel  = (bus.PRESCALE == 6'd16) ? 6'd16 : (bus.PRESCALE == 6'd32) ? 6'd32 : 6'd8;
  assign w_half  = r_p >> 1;
  assign w_start = (r_state == IDLE) && !bus.RX_IN && r_prev;
  assign w_last  = r_edge == r_p - 6'd1;
  assign w_res   = r_edge == w_half + 6'd2;
  assign w_maj   = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_smp[2]) | (r_smp[1] & r_smp[2]);
  assign w_good  = !r_perr && !r_serr;
  always_ff @(posedge CLK)
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_start ? START : IDLE;
      START:   w_next = !w_last ? START : (w_maj ? IDLE : DATA);
      DATA:    w_next = (w_last && r_bit == 5'(DATA_WIDTH - 1)) ? (r_pe ? PARITY : STOP) : DATA;
      PARITY:  w_next = w_last ? STOP : PARITY;
      STOP:    w_next = w_last ? IDLE : STOP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_prev    <= 1'b1;
      r_p       <= 6'd8;
      r_pe      <= 1'b0;
      r_pt      <= 1'b0;
      r_edge    <= '0;
      r_bit     <= '0;
      r_smp     <= '0;
      r_shift   <= '0;
      r_perr    <= 1'b0;
      r_serr    <= 1'b0;
      r_data    <= '0;
      r_dv      <= 1'b0;
      r_par_err <= 1'b0;
      r_stp_err <= 1'b0;
    end else begin
      r_prev    <= bus.RX_IN;
      r_dv      <= 1'b0;
      r_par_err <= 1'b0;
      r_stp_err <= 1'b0;
      if (w_start) begin
        r_p    <= w_psel;
        r_pe   <= bus.PAR_EN;
        r_pt   <= bus.PAR_TYP;
        r_edge <= 6'd1;
        r_bit  <= '0;
        r_perr <= 1'b0;
        r_serr <= 1'b0;
      end else if (r_state != IDLE) begin
        r_edge <= w_last ? 6'd0 : r_edge + 6'd1;
        if (r_edge == w_half - 6'd1) r_smp[0] <= bus.RX_IN;
        if (r_edge == w_half)        r_smp[1] <= bus.RX_IN;
        if (r_edge == w_half + 6'd1) r_smp[2] <= bus.RX_IN;
        if (w_res && r_state == DATA)   r_shift <= {w_maj, r_shift[DATA_WIDTH-1:1]};
        if (w_res && r_state == PARITY) r_perr  <= w_maj != ((^r_shift) ^ r_pt);
        if (w_res && r_state == STOP)   r_serr  <= !w_maj;
        if (w_last && r_state == DATA)  r_bit   <= r_bit + 5'd1;
        // frame end: pulses become visible in the cycle after the last stop-bit edge
        if (w_last && r_state == STOP) begin
          r_dv      <= w_good;
          r_par_err <= r_perr;
          r_stp_err <= r_serr;
          if (w_good) r_data <= r_shift;
        end
      end
    end
  end
  assign bus.P_DATA     = r_data;
  assign bus.Data_Valid = r_dv;
  assign bus.Par_Err    = r_par_err;
  assign bus.Stp_Err    = r_stp_err;
  assign bus.Busy       = r_state != IDLE;
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: prebuilt line waveform, frame-level reference model, per-cycle output compare
module tb_uart_rx_core;
  localparam int DW = 8;
  localparam int L  = 20000;
  logic clk = 1'b0;
  logic rst_i;
  int   checks = 0, errors = 0, cyc = 0, wp = 0;
  bit   run = 1'b0;
  logic          line [L];
  logic          rst  [L];
  logic [5:0]    pre  [L];
  logic          pen  [L];
  logic          ptyp [L];
  logic          exp_dv [L], exp_pe [L], exp_se [L], exp_busy [L], pd_set [L];
  logic [DW-1:0] exp_pd [L], pd_val [L];
  uart_rx_if #(.DATA_WIDTH(DW)) bus ();
  uart_rx_core #(.DATA_WIDTH(DW)) dut (.CLK(clk), .RST(rst_i), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int req, input int cy);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h want %0h", nm, cy, act, req);
    end
  endtask
  function automatic int psel(input logic [5:0] x);
    return (x == 6'd16) ? 16 : (x == 6'd32) ? 32 : 8;
  endfunction
  function automatic logic maj(input int t, input int p);
    int s;
    s = int'(line[t+p/2-1]) + int'(line[t+p/2]) + int'(line[t+p/2+1]);
    return s >= 2;
  endfunction
  task automatic put(input logic v, input int n);
    for (int i = 0; i < n; i++) if (wp < L) begin line[wp] = v; wp++; end
  endtask
  task automatic frame(input int d, input logic [5:0] pc, input logic pe, input logic pt,
                       input logic bp, input logic bs, input bit spk, output int t0);
    int p, nb;
    logic [DW-1:0] dd;
    logic b [0:DW+2];
    dd = d[DW-1:0];
    p  = psel(pc);
    nb = 2 + DW + int'(pe);
    t0 = wp;
    pre[t0] = pc; pen[t0] = pe; ptyp[t0] = pt;
    b[0] = 1'b0;
    for (int i = 0; i < DW; i++) b[1+i] = dd[i];
    if (pe) b[DW+1] = (^dd) ^ pt ^ bp;
    b[nb-1] = ~bs;
    for (int k = 0; k < nb; k++) put(b[k], p);
    if (spk)
      for (int k = 0; k < nb; k++)
        if ($urandom_range(0, 3) == 0) begin
          int at;
          at = t0 + k*p + p/2 - 1 + int'($urandom_range(0, 2));
          line[at] = ~line[at];
        end
  endtask
  // frame-level model: find start edges, majority-vote each bit window, schedule end-of-frame results
  task automatic model();
    int c, t0, p, n, f, r, e;
    logic prev, pe, pt, perr, serr;
    logic [DW-1:0] data, cur;
    c = 0; prev = 1'b1;
    for (int i = 0; i < L; i++) begin
      exp_dv[i] = 0; exp_pe[i] = 0; exp_se[i] = 0; exp_busy[i] = 0; pd_set[i] = 0; pd_val[i] = '0;
    end
    while (c < L) begin
      if (rst[c]) begin
        prev = 1'b1;
        if (c + 1 < L) begin pd_set[c+1] = 1; pd_val[c+1] = '0; end
        c++;
      end else if (!line[c] && prev) begin
        t0 = c; p = psel(pre[c]); pe = pen[c]; pt = ptyp[c];
        n = 2 + DW + int'(pe);
        f = maj(t0, p) ? p : n*p;
        if (t0 + f >= L) break;
        r = -1;
        for (int k = t0 + 1; k < t0 + f; k++) if (rst[k] && r < 0) r = k;
        if (r >= 0) begin
          for (int k = t0 + 1; k <= r; k++) exp_busy[k] = 1;
          c = r;
        end else begin
          for (int k = t0 + 1; k < t0 + f; k++) exp_busy[k] = 1;
          if (f != p) begin
            for (int i = 0; i < DW; i++) data[i] = maj(t0 + (1+i)*p, p);
            perr = pe && (maj(t0 + (DW+1)*p, p) != ((^data) ^ pt));
            serr = !maj(t0 + (n-1)*p, p);
            e = t0 + f;
            exp_dv[e] = !perr && !serr; exp_pe[e] = perr; exp_se[e] = serr;
            if (!perr && !serr) begin pd_set[e] = 1; pd_val[e] = data; end
          end
          prev = line[t0+f-1];
          c = t0 + f;
        end
      end else begin
        prev = line[c];
        c++;
      end
    end
    cur = '0;
    for (int i = 0; i < L; i++) begin
      if (pd_set[i]) cur = pd_val[i];
      exp_pd[i] = cur;
    end
  endtask
  always @(negedge clk)
    if (run && cyc >= 1) begin
      chk("Data_Valid", int'(bus.Data_Valid), int'(exp_dv[cyc]), cyc);
      chk("Par_Err", int'(bus.Par_Err), int'(exp_pe[cyc]), cyc);
      chk("Stp_Err", int'(bus.Stp_Err), int'(exp_se[cyc]), cyc);
      chk("Busy", int'(bus.Busy), int'(exp_busy[cyc]), cyc);
      chk("P_DATA", int'(bus.P_DATA), int'(exp_pd[cyc]), cyc);
    end
  initial begin
    int t1, t2, t3, t3b, g, f4, t5, f5, a, b2, c3, s;
    logic [5:0] pc;
    for (int i = 0; i < L; i++) begin
      line[i] = 1'b1; rst[i] = 1'b0;
      pre[i] = 6'($urandom_range(0, 63)); pen[i] = 1'($urandom); ptyp[i] = 1'($urandom);
    end
    rst[0] = 1; rst[1] = 1; rst[2] = 1;
    wp = 3;
    put(1, 5);
    frame(8'hA5, 6'd8, 1, 0, 0, 0, 0, t1);  put(1, 10);
    frame(8'h3C, 6'd8, 1, 1, 1, 0, 0, t2);  put(1, 10);
    frame(8'h81, 6'd16, 0, 0, 0, 0, 0, t3); put(1, 10);
    frame(8'h81, 6'd16, 0, 0, 0, 0, 0, t3b);
    line[t3b + 2*16 + 8] = ~line[t3b + 2*16 + 8];
    put(1, 10);
    g = wp; pre[g] = 6'd8;
    put(0, 3); put(1, 5);
    frame(8'h5A, 6'd8, 0, 0, 0, 0, 0, f4); put(1, 10);
    frame(8'h77, 6'd8, 0, 0, 0, 1, 0, t5); put(0, 30); put(1, 3);
    frame(8'h99, 6'd8, 1, 0, 0, 0, 0, f5); put(1, 10);
    frame(8'h12, 6'd8, 1, 0, 0, 0, 0, a);
    frame(8'h34, 6'd8, 1, 0, 0, 0, 0, b2);
    frame(8'h56, 6'd8, 1, 0, 0, 0, 0, c3);
    rst[c3 + 30] = 1;
    wp = c3 + 31;
    put(1, 100);
    while (wp < L - 1200) begin
      int t;
      case ($urandom_range(0, 3))
        0: pc = 6'd8;
        1: pc = 6'd16;
        2: pc = 6'd32;
        default: pc = 6'($urandom_range(0, 63));
      endcase
      frame(int'($urandom), pc, 1'($urandom), 1'($urandom),
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, 1, t);
      if ($urandom_range(0, 14) == 0) rst[t + int'($urandom_range(1, 60))] = 1;
      put(1, int'($urandom_range(0, 20)));
    end
    model();
    chk("m_busy_t1_0", int'(exp_busy[t1]), 0, t1);
    chk("m_busy_t1_1", int'(exp_busy[t1+1]), 1, t1+1);
    chk("m_busy_t1_87", int'(exp_busy[t1+87]), 1, t1+87);
    chk("m_busy_t1_88", int'(exp_busy[t1+88]), 0, t1+88);
    chk("m_dv_t1", int'(exp_dv[t1+88]), 1, t1+88);
    chk("m_pd_t1", int'(exp_pd[t1+88]), 'hA5, t1+88);
    chk("m_pe_t2", int'(exp_pe[t2+88]), 1, t2+88);
    chk("m_dv_t2", int'(exp_dv[t2+88]), 0, t2+88);
    chk("m_pd_t2", int'(exp_pd[t2+88]), 'hA5, t2+88);
    chk("m_dv_t3", int'(exp_dv[t3+160]), 1, t3+160);
    chk("m_pd_t3", int'(exp_pd[t3+160]), 'h81, t3+160);
    chk("m_dv_t3b", int'(exp_dv[t3b+160]), 1, t3b+160);
    chk("m_pd_t3b", int'(exp_pd[t3b+160]), 'h81, t3b+160);
    chk("m_busy_g7", int'(exp_busy[g+7]), 1, g+7);
    chk("m_busy_g8", int'(exp_busy[g+8]), 0, g+8);
    s = 0;
    for (int i = g; i <= g + 8; i++) s += int'(exp_dv[i]) + int'(exp_pe[i]) + int'(exp_se[i]);
    chk("m_glitch_nopulse", s, 0, g);
    chk("m_dv_f4", int'(exp_dv[f4+80]), 1, f4+80);
    chk("m_pd_f4", int'(exp_pd[f4+80]), 'h5A, f4+80);
    chk("m_se_t5", int'(exp_se[t5+80]), 1, t5+80);
    chk("m_dv_t5", int'(exp_dv[t5+80]), 0, t5+80);
    chk("m_busy_low", int'(exp_busy[t5+100]), 0, t5+100);
    chk("m_dv_f5", int'(exp_dv[f5+88]), 1, f5+88);
    chk("m_pd_f5", int'(exp_pd[f5+88]), 'h99, f5+88);
    chk("m_b2b_gap", b2 - a, 88, b2);
    chk("m_dv_a", int'(exp_dv[a+88]), 1, a+88);
    chk("m_pd_a", int'(exp_pd[a+88]), 'h12, a+88);
    chk("m_dv_b", int'(exp_dv[a+176]), 1, a+176);
    chk("m_pd_b", int'(exp_pd[a+176]), 'h34, a+176);
    chk("m_busy_rst_pre", int'(exp_busy[c3+30]), 1, c3+30);
    chk("m_busy_rst", int'(exp_busy[c3+31]), 0, c3+31);
    chk("m_pd_rst", int'(exp_pd[c3+31]), 0, c3+31);
    s = 0;
    for (int i = c3 + 31; i < c3 + 120; i++) s += int'(exp_dv[i]) + int'(exp_pe[i]) + int'(exp_se[i]);
    chk("m_rst_nopulse", s, 0, c3+31);
    run = 1'b1;
    for (int c = 0; c < L; c++) begin
      cyc = c;
      rst_i = rst[c];
      bus.RX_IN = line[c];
      bus.PRESCALE = pre[c];
      bus.PAR_EN = pen[c];
      bus.PAR_TYP = ptyp[c];
      @(posedge clk);
      #1;
    end
    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Serial receiver that is the far end of the UART_TX frame format: start bit (0), DATA_WIDTH data bits LSB first, optional parity bit, one stop bit (1).
- Oversamples RX_IN on CLK at PRESCALE cycles per bit and majority-votes three mid-bit samples.
- Checks parity and stop bit, then presents a parallel word with a one-cycle valid pulse.
- Sits between the pad synchronizer and the system-side consumer; RX_IN is already synchronized to CLK.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (range 4..16).

Ports:
- CLK  input  1  oversampling clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- RX_IN  input  1  serial line; idles high.
- PRESCALE  input  6  CLK cycles per bit. Legal values are 8, 16 and 32; any other value is treated as 8.
- PAR_EN  input  1  1 = frame contains a parity bit.
- PAR_TYP  input  1  0 = even, 1 = odd.
- P_DATA  output  DATA_WIDTH  last good received word.
- Data_Valid  output  1  one-cycle pulse: P_DATA updated.
- Par_Err  output  1  one-cycle pulse: parity mismatch.
- Stp_Err  output  1  one-cycle pulse: stop bit sampled 0.
- Busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (RST=1 at a rising edge):
  - P_DATA=0, Data_Valid=0, Par_Err=0, Stp_Err=0, Busy=0.
  - FSM goes to IDLE, counters are zeroed, prev_rx register is set to 1.
  - Reset mid-frame abandons the frame; no pulse is emitted.
- Start detection:
  - In IDLE, a start is detected when RX_IN=0 and prev_rx=1 (falling edge).
  - The detect cycle is edge 0 of the start bit.
  - PRESCALE, PAR_EN and PAR_TYP are latched at the detect cycle and ignored until the frame ends.
- Edge counter:
  - edge_cnt runs 0..P-1 per bit (P = latched PRESCALE), then wraps to 0 and bit_cnt increments.
- Sampling:
  - RX_IN is sampled at edge_cnt P/2-1, P/2 and P/2+1.
  - The bit value is the majority (2 of 3) of those samples and is resolved at edge P/2+2.
- FSM states and transitions: IDLE -> START -> DATA -> PARITY (only if PAR_EN) -> STOP -> IDLE. Each transition occurs at edge_cnt=P-1.
  - START: a resolved value of 1 is a glitch. Return to IDLE at edge P-1 with no pulses.
  - DATA: bits are shifted in LSB first into an internal shift register over DATA_WIDTH bit periods.
  - PARITY: expected = XOR(data) for even, ~XOR(data) for odd. A mismatch sets an internal par flag.
  - STOP: expected 1. A resolved 0 sets an internal stp flag.
- Frame end (cycle after edge P-1 of STOP):
  - No flags: P_DATA <= shift register and Data_Valid=1 for exactly one cycle.
  - par flag: Par_Err=1 for one cycle.
  - stp flag: Stp_Err=1 for one cycle.
  - Both flags: both pulses fire together.
  - On any error, Data_Valid stays 0 and P_DATA keeps its previous value.
- Latency: Data_Valid rises at cycle N*P counted from the start-detect cycle (cycle 0), where N = 2 + DATA_WIDTH + PAR_EN.
- Busy:
  - Rises the cycle after start detect.
  - Falls in the same cycle that the end-of-frame pulses are driven.
  - On a glitch abort, falls the cycle after START edge P-1.
- Back-to-back frames: a falling edge on the cycle right after frame end is detected, because prev_rx=1 from the stop bit.
- Break or stop error with the line held low: no new start is detected until RX_IN has returned to 1 for at least one cycle.
- Input changes to PRESCALE, PAR_EN or PAR_TYP during a frame have no effect on that frame.

Test Plan:
1. Good frame, even parity: DATA_WIDTH=8, P=8, PAR_EN=1, PAR_TYP=0, frame 0,1,0,1,0,0,1,0,1,0,1 (0xA5, parity 0) -> Data_Valid pulse at cycle 88, P_DATA=0xA5, Par_Err=Stp_Err=0, Busy high cycles 1..87.
2. Parity error: odd parity, data 0x3C with parity bit 0 (expected 1) -> Par_Err pulse at cycle 88, Data_Valid stays 0, P_DATA stays 0xA5.
3. No parity, P=16, data 0x81 -> Data_Valid at cycle 160, P_DATA=0x81. Repeat with a one-cycle high spike on RX_IN at edge P/2 of data bit 1 -> still 0x81 (majority vote).
4. Start glitch: RX_IN low for 3 cycles, then high, P=8 -> no pulses, Busy falls at cycle 8. A real frame sent immediately after is received correctly.
5. Stop error: stop bit driven 0, line held low -> Stp_Err pulse at frame end, no Data_Valid, no new start while low. After RX_IN goes high then low again, a new frame is received normally.
6. Back-to-back and reset: two frames 0x12, 0x34 with no idle gap -> two Data_Valid pulses 88 cycles apart. RST=1 mid-data of a third frame -> all outputs 0 next cycle, no pulse.
